// File: rtl/chunked_serial_adder_if.sv
// Handshake and data bundle for chunked_serial_adder.
// The operand side uses in_valid/in_ready and the result side uses out_valid/out_ready.
`timescale 1ns/1ps
interface chunked_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Carry;
    logic             Overflow;

    modport master (
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, Sum, Carry, Overflow
    );

    modport slave (
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, Sum, Carry, Overflow
    );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: adds CHUNK bits per clock and carries between chunks through a register.
// Sum/Carry/Overflow are qualified by out_valid and hold their last values afterwards.
`timescale 1ns/1ps
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chunked_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic             carry_out_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CHUNK-1:0] sum_q [N];
    logic [WIDTH-1:0] sum_flat;

    logic [CHUNK-1:0] chunk_a_d;
    logic [CHUNK-1:0] chunk_b_d;
    logic [CHUNK:0]   chunk_total_d;
    logic [CHUNK-1:0] chunk_sum_d;
    logic             chunk_cout_d;
    logic             msb_cin_d;

    always_comb begin
        chunk_a_d = '0;
        chunk_b_d = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                chunk_a_d = a_q[i*CHUNK +: CHUNK];
                chunk_b_d = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign chunk_total_d = {1'b0, chunk_a_d} + {1'b0, chunk_b_d} + {{CHUNK{1'b0}}, carry_q};
    assign chunk_sum_d   = chunk_total_d[CHUNK-1:0];
    assign chunk_cout_d  = chunk_total_d[CHUNK];
    // Carry into the chunk's top bit is recovered from that bit's own sum.
    assign msb_cin_d     = chunk_a_d[CHUNK-1] ^ chunk_b_d[CHUNK-1] ^ chunk_sum_d[CHUNK-1];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chunk
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sum_q[gi] <= '0;
                end else if (state_q == RUN && k_q == KW'(gi)) begin
                    sum_q[gi] <= chunk_sum_d;
                end
            end
            assign sum_flat[gi*CHUNK +: CHUNK] = sum_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        carry_q    <= bus.c;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    carry_q <= chunk_cout_d;
                    k_q     <= k_q + KW'(1);
                    if (k_q == KW'(N - 1)) begin
                        k_q         <= '0;
                        carry_out_q <= chunk_cout_d;
                        ovf_q       <= msb_cin_d ^ chunk_cout_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Sum       = sum_flat;
    assign bus.Carry     = carry_out_q;
    assign bus.Overflow  = ovf_q;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed and randomised checks of chunked_serial_adder at several WIDTH/CHUNK settings.
`timescale 1ns/1ps
module tb_chunked_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    chunked_serial_adder_if #(.WIDTH(1))  if1 ();
    chunked_serial_adder_if #(.WIDTH(16)) if16 ();
    chunked_serial_adder_if #(.WIDTH(32)) if8 ();
    chunked_serial_adder_if #(.WIDTH(32)) if32 ();

    chunked_serial_adder #(.WIDTH(1),  .CHUNK(1))  u_w1   (.clk(clk), .rst_n(rst_n), .bus(if1));
    chunked_serial_adder #(.WIDTH(16), .CHUNK(4))  u_w16  (.clk(clk), .rst_n(rst_n), .bus(if16));
    chunked_serial_adder #(.WIDTH(32), .CHUNK(8))  u_w32c8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    chunked_serial_adder #(.WIDTH(32), .CHUNK(32)) u_w32c32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    // Shared random-test stimulus, steered to one 32-bit instance by sel.
    logic        sel = 1'b0;
    logic        x_in_valid = 1'b0;
    logic        x_out_ready = 1'b0;
    logic [31:0] x_a = '0;
    logic [31:0] x_b = '0;
    logic        x_c = 1'b0;

    assign if8.in_valid   = x_in_valid & ~sel;
    assign if32.in_valid  = x_in_valid & sel;
    assign if8.out_ready  = x_out_ready & ~sel;
    assign if32.out_ready = x_out_ready & sel;
    assign if8.a  = x_a;
    assign if8.b  = x_b;
    assign if8.c  = x_c;
    assign if32.a = x_a;
    assign if32.b = x_b;
    assign if32.c = x_c;

    logic        r_in_ready, r_out_valid, r_carry, r_ovf;
    logic [31:0] r_sum;
    assign r_in_ready  = sel ? if32.in_ready  : if8.in_ready;
    assign r_out_valid = sel ? if32.out_valid : if8.out_valid;
    assign r_sum       = sel ? if32.Sum       : if8.Sum;
    assign r_carry     = sel ? if32.Carry     : if8.Carry;
    assign r_ovf       = sel ? if32.Overflow  : if8.Overflow;

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic c);
        if16.a = a;
        if16.b = b;
        if16.c = c;
        if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
    endtask

    task automatic wait16(output int lat);
        lat = 0;
        while (!if16.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release16();
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        if16.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (if16.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", if16.in_ready); end
        n_checks++; if (if16.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", if16.out_valid); end
        n_checks++; if (if16.Sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h expected 0000", if16.Sum); end
        n_checks++; if ({if16.Carry, if16.Overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {if16.Carry, if16.Overflow}); end
        n_checks++; if (if1.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_w1_in_ready: got %b expected 0", if1.in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (if16.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", if16.in_ready); end
        n_checks++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_w1_in_ready: got %b expected 1", if1.in_ready); end
        $display("txn reset: released");
    endtask

    task automatic test_full_adder();
        logic [7:0] sum_tbl = 8'h96;
        logic [7:0] carry_tbl = 8'hE8;
        logic [7:0] ovf_tbl = 8'h42;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            if1.a = v[2];
            if1.b = v[1];
            if1.c = v[0];
            if1.in_valid = 1'b1;
            @(posedge clk); #1;
            if1.in_valid = 1'b0;
            n_checks++; if (if1.out_valid !== 1'b0) begin n_fail++; $display("FAIL fa_early_valid[%0d]: got %b expected 0", i, if1.out_valid); end
            @(posedge clk); #1;
            n_checks++; if (if1.out_valid !== 1'b1) begin n_fail++; $display("FAIL fa_valid[%0d]: got %b expected 1", i, if1.out_valid); end
            n_checks++; if (if1.Sum !== sum_tbl[i]) begin n_fail++; $display("FAIL fa_sum[%0d]: got %b expected %b", i, if1.Sum, sum_tbl[i]); end
            n_checks++; if (if1.Carry !== carry_tbl[i]) begin n_fail++; $display("FAIL fa_carry[%0d]: got %b expected %b", i, if1.Carry, carry_tbl[i]); end
            n_checks++; if (if1.Overflow !== ovf_tbl[i]) begin n_fail++; $display("FAIL fa_ovf[%0d]: got %b expected %b", i, if1.Overflow, ovf_tbl[i]); end
            $display("txn full_adder a=%b b=%b c=%b -> Sum=%b Carry=%b", v[2], v[1], v[0], if1.Sum, if1.Carry);
            if1.out_ready = 1'b1;
            @(posedge clk); #1;
            if1.out_ready = 1'b0;
            n_checks++; if ({if1.out_valid, if1.in_ready} !== 2'b01) begin n_fail++; $display("FAIL fa_handback[%0d]: got %b expected 01", i, {if1.out_valid, if1.in_ready}); end
        end
    endtask

    task automatic test_ripple();
        int lat;
        start16(16'hFFFF, 16'h0000, 1'b1);
        wait16(lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ripple_latency: got %0d expected 4", lat); end
        n_checks++; if (if16.Sum !== 16'h0000) begin n_fail++; $display("FAIL ripple_sum: got %h expected 0000", if16.Sum); end
        n_checks++; if ({if16.Carry, if16.Overflow} !== 2'b10) begin n_fail++; $display("FAIL ripple_flags: got %b expected 10", {if16.Carry, if16.Overflow}); end
        $display("txn ripple FFFF+0000+1 -> Sum=%h Carry=%b", if16.Sum, if16.Carry);
        release16();
        n_checks++; if ({if16.out_valid, if16.in_ready} !== 2'b01) begin n_fail++; $display("FAIL ripple_handback: got %b expected 01", {if16.out_valid, if16.in_ready}); end
    endtask

    task automatic test_overflow();
        logic [15:0] ta [2] = '{16'h7FFF, 16'h8000};
        logic [15:0] tb [2] = '{16'h0001, 16'h8000};
        logic [15:0] ts [2] = '{16'h8000, 16'h0000};
        logic [1:0]  tf [2] = '{2'b01, 2'b11};
        int lat;
        for (int i = 0; i < 2; i++) begin
            start16(ta[i], tb[i], 1'b0);
            wait16(lat);
            n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ovf_latency[%0d]: got %0d expected 4", i, lat); end
            n_checks++; if (if16.Sum !== ts[i]) begin n_fail++; $display("FAIL ovf_sum[%0d]: got %h expected %h", i, if16.Sum, ts[i]); end
            n_checks++; if ({if16.Carry, if16.Overflow} !== tf[i]) begin n_fail++; $display("FAIL ovf_flags[%0d]: got %b expected %b", i, {if16.Carry, if16.Overflow}, tf[i]); end
            $display("txn overflow %h+%h -> Sum=%h Carry=%b Overflow=%b", ta[i], tb[i], if16.Sum, if16.Carry, if16.Overflow);
            release16();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start16(16'h1111, 16'h2222, 1'b0);
        wait16(lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d expected 4", lat); end
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                if16.a = 16'hFFFF;
                if16.b = 16'hFFFF;
                if16.c = 1'b1;
                if16.in_valid = 1'b1;
            end
            n_checks++; if (if16.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, if16.out_valid); end
            n_checks++; if (if16.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, if16.in_ready); end
            n_checks++; if (if16.Sum !== 16'h3333) begin n_fail++; $display("FAIL bp_sum[%0d]: got %h expected 3333", i, if16.Sum); end
            @(posedge clk); #1;
        end
        if16.in_valid = 1'b0;
        release16();
        n_checks++; if ({if16.out_valid, if16.in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_handback: got %b expected 01", {if16.out_valid, if16.in_ready}); end
        n_checks++; if (if16.Sum !== 16'h3333) begin n_fail++; $display("FAIL bp_sum_kept: got %h expected 3333", if16.Sum); end
        @(posedge clk); #1;
        n_checks++; if ({if16.out_valid, if16.in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_no_second: got %b expected 01", {if16.out_valid, if16.in_ready}); end
        $display("txn backpressure 1111+2222 -> Sum=%h after 10 stalled cycles", if16.Sum);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start16(16'hABCD, 16'h1111, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({if16.out_valid, if16.in_ready} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_hs: got %b expected 00", {if16.out_valid, if16.in_ready}); end
        n_checks++; if (if16.Sum !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_sum: got %h expected 0000", if16.Sum); end
        n_checks++; if ({if16.Carry, if16.Overflow} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_flags: got %b expected 00", {if16.Carry, if16.Overflow}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({if16.out_valid, if16.in_ready} !== 2'b01) begin n_fail++; $display("FAIL mid_reset_release: got %b expected 01", {if16.out_valid, if16.in_ready}); end
        start16(16'h1234, 16'h4321, 1'b0);
        wait16(lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL fresh_latency: got %0d expected 4", lat); end
        n_checks++; if (if16.Sum !== 16'h5555) begin n_fail++; $display("FAIL fresh_sum: got %h expected 5555", if16.Sum); end
        n_checks++; if ({if16.Carry, if16.Overflow} !== 2'b00) begin n_fail++; $display("FAIL fresh_flags: got %b expected 00", {if16.Carry, if16.Overflow}); end
        $display("txn reset_mid_run then 1234+4321 -> Sum=%h Carry=%b", if16.Sum, if16.Carry);
        release16();
    endtask

    task automatic test_random(input logic which, input int count);
        logic [32:0] exp_v;
        logic        exp_ovf, acc_now, accepted, done, v_now;
        int          guard;
        sel = which;
        for (int n = 0; n < count; n++) begin
            x_a = $urandom;
            x_b = $urandom;
            x_c = 1'($urandom);
            exp_v   = {1'b0, x_a} + {1'b0, x_b} + {32'd0, x_c};
            exp_ovf = (x_a[31] == x_b[31]) && (exp_v[31] != x_a[31]);
            x_in_valid = 1'b1;
            accepted = 1'b0;
            guard = 0;
            while (!accepted && guard < 50) begin
                acc_now = r_in_ready;
                @(posedge clk); #1;
                guard++;
                if (acc_now) accepted = 1'b1;
            end
            x_in_valid = 1'b0;
            n_checks++; if (!accepted) begin n_fail++; $display("FAIL rand_accept[%0d]: got no acceptance expected in_ready within 50 cycles", n); end
            done = 1'b0;
            guard = 0;
            while (!done && guard < 100) begin
                x_out_ready = 1'($urandom);
                v_now = r_out_valid;
                if (v_now && x_out_ready) begin
                    n_checks++; if ({r_carry, r_sum} !== exp_v) begin n_fail++; $display("FAIL rand_sum[%0d]: got %b_%h expected %b_%h", n, r_carry, r_sum, exp_v[32], exp_v[31:0]); end
                    n_checks++; if (r_ovf !== exp_ovf) begin n_fail++; $display("FAIL rand_ovf[%0d]: got %b expected %b", n, r_ovf, exp_ovf); end
                    done = 1'b1;
                end
                @(posedge clk); #1;
                guard++;
            end
            x_out_ready = 1'b0;
            n_checks++; if (!done) begin n_fail++; $display("FAIL rand_transfer[%0d]: got no out_valid expected one transfer within 100 cycles", n); end
            n_checks++; if ({r_out_valid, r_in_ready} !== 2'b01) begin n_fail++; $display("FAIL rand_dup[%0d]: got %b expected 01", n, {r_out_valid, r_in_ready}); end
            $display("txn random chunk=%0d %h+%h+%b -> Sum=%h Carry=%b Overflow=%b", which ? 32 : 8, x_a, x_b, x_c, r_sum, r_carry, r_ovf);
        end
    endtask

    initial begin
        if1.in_valid = 1'b0;  if1.out_ready = 1'b0;
        if1.a = 1'b0; if1.b = 1'b0; if1.c = 1'b0;
        if16.in_valid = 1'b0; if16.out_ready = 1'b0;
        if16.a = '0; if16.b = '0; if16.c = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_full_adder();
        test_ripple();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_random(1'b0, 1000);
        test_random(1'b1, 1000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end
endmodule
